// File: rtl/latch_wr_sched_pkg.sv
// Shared types and helpers for the latch-array write scheduler.
package latch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        PULSE = 2'b10,
        HOLD  = 2'b11
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // One bit of a one-hot row decode; rows at or beyond depth never select.
    function automatic logic row_sel(input logic [31:0] addr,
                                     input logic [31:0] row,
                                     input logic [31:0] depth);
        return (addr == row) && (addr < depth);
    endfunction

endpackage

// File: rtl/latch_wr_sched_if.sv
// Two-requester write handshake between CPU-side sources and the scheduler.
interface latch_wr_sched_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             a_valid;
    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/latch_wr_sched_arb.sv
// Two-input round-robin arbiter; the pointer only moves on a contended accept.
module latch_rr_arb2
    import latch_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic       grant_o
);
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = ptr_q;
        ptr_d   = ptr_q;
        case (valid_i)
            2'b01:   grant_o = REQ_A;
            2'b10:   grant_o = REQ_B;
            default: grant_o = ptr_q;
        endcase
        if (accept_i && (&valid_i)) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a transparent-high latch array: setup, row pulse, hold.
// Optional sticky error flag when LATCH_WR_SCHED_ERRCHK_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, READY may assert
// SETUP | LAT_D driven, enables low
// PULSE | one row enable high, driven straight from en_q
// HOLD  | enables low, LAT_D still held
module latch_wr_sched
    import latch_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    latch_wr_sched_if.slave  req,
    output logic [WIDTH-1:0] lat_d_o,
    output logic [DEPTH-1:0] lat_en_o,
    output logic             busy_o
`ifdef LATCH_WR_SCHED_ERRCHK_EN
    ,
    output logic             err_o
`endif
);
    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] lat_d_q;
    logic [DEPTH-1:0] en_q;
    logic             busy_q;

    logic             grant;
    logic             idle;
    logic             accept;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [DEPTH-1:0] dec_d;

    assign idle     = (state_q == IDLE);
    assign accept   = idle && (req.a_valid || req.b_valid);
    assign sel_addr = (grant == REQ_B) ? req.b_addr : req.a_addr;
    assign sel_data = (grant == REQ_B) ? req.b_data : req.a_data;

    assign req.a_ready = idle && req.a_valid && (grant == REQ_A);
    assign req.b_ready = idle && req.b_valid && (grant == REQ_B);

    latch_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  ({req.b_valid, req.a_valid}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Decode is registered into en_q, so row enables never see decode glitches.
    always_comb begin
        dec_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            dec_d[r] = row_sel(32'(addr_q), 32'(r), 32'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lat_d_q <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= sel_addr;
                        lat_d_q <= sel_data;
                        cnt_q   <= SETUP_LD;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        en_q    <= dec_d;
                        cnt_q   <= PULSE_LD;
                        state_q <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        en_q    <= '0;
                        cnt_q   <= HOLD_LD;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    en_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lat_d_o  = lat_d_q;
    assign lat_en_o = en_q;
    assign busy_o   = busy_q;

`ifdef LATCH_WR_SCHED_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((accept && (32'(sel_addr) >= $unsigned(DEPTH))) ||
                     ((|en_q) && (state_q != PULSE))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif
endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: three parameterisations share one stimulus stream,
// each checked against a transaction-level schedule model.
module tb_latch_wr_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    latch_wr_sched_if #(.WIDTH(8), .AW(4)) i0 ();
    latch_wr_sched_if #(.WIDTH(8), .AW(4)) i1 ();
    latch_wr_sched_if #(.WIDTH(8), .AW(4)) i2 ();

    logic [7:0]  ld0, ld1, ld2;
    logic [15:0] en0, en1;
    logic [11:0] en2;
    logic        bz0, bz1, bz2;
`ifdef LATCH_WR_SCHED_ERRCHK_EN
    logic        er0, er1, er2;
`endif

    latch_wr_sched #(.WIDTH(8), .DEPTH(16), .AW(4),
                     .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) d0 (
        .clk(clk), .rst_n(rst_n), .req(i0),
        .lat_d_o(ld0), .lat_en_o(en0), .busy_o(bz0)
`ifdef LATCH_WR_SCHED_ERRCHK_EN
        , .err_o(er0)
`endif
    );

    latch_wr_sched #(.WIDTH(8), .DEPTH(16), .AW(4),
                     .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) d1 (
        .clk(clk), .rst_n(rst_n), .req(i1),
        .lat_d_o(ld1), .lat_en_o(en1), .busy_o(bz1)
`ifdef LATCH_WR_SCHED_ERRCHK_EN
        , .err_o(er1)
`endif
    );

    latch_wr_sched #(.WIDTH(8), .DEPTH(12), .AW(4),
                     .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) d2 (
        .clk(clk), .rst_n(rst_n), .req(i2),
        .lat_d_o(ld2), .lat_en_o(en2), .busy_o(bz2)
`ifdef LATCH_WR_SCHED_ERRCHK_EN
        , .err_o(er2)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;

    int          m_s [3] = '{1, 2, 1};
    int          m_p [3] = '{1, 3, 1};
    int          m_h [3] = '{1, 2, 1};
    int          m_dp[3] = '{16, 16, 12};
    longint      t_acc  [3];
    longint      free_at[3];
    int          cur_addr[3];
    logic [7:0]  m_ld [3];
    bit          m_ptr[3];
    bit          m_err[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            t_acc[k]    = -1000;
            free_at[k]  = -1000;
            cur_addr[k] = 0;
            m_ld[k]     = 8'h00;
            m_ptr[k]    = 1'b0;
            m_err[k]    = 1'b0;
        end
    endtask

    task automatic get_obs(input int k, output logic [31:0] d, output logic [31:0] en,
                           output logic [31:0] bz, output logic [31:0] ra,
                           output logic [31:0] rb, output logic [31:0] er);
        er = 32'd0;
        case (k)
            0: begin
                d = 32'(ld0); en = 32'(en0); bz = 32'(bz0);
                ra = 32'(i0.a_ready); rb = 32'(i0.b_ready);
`ifdef LATCH_WR_SCHED_ERRCHK_EN
                er = 32'(er0);
`endif
            end
            1: begin
                d = 32'(ld1); en = 32'(en1); bz = 32'(bz1);
                ra = 32'(i1.a_ready); rb = 32'(i1.b_ready);
`ifdef LATCH_WR_SCHED_ERRCHK_EN
                er = 32'(er1);
`endif
            end
            default: begin
                d = 32'(ld2); en = 32'(en2); bz = 32'(bz2);
                ra = 32'(i2.a_ready); rb = 32'(i2.b_ready);
`ifdef LATCH_WR_SCHED_ERRCHK_EN
                er = 32'(er2);
`endif
            end
        endcase
    endtask

    task automatic drive(input bit av, input logic [3:0] aa, input logic [7:0] ad,
                         input bit bv, input logic [3:0] ba, input logic [7:0] bd);
        i0.a_valid = av; i0.a_addr = aa; i0.a_data = ad;
        i0.b_valid = bv; i0.b_addr = ba; i0.b_data = bd;
        i1.a_valid = av; i1.a_addr = aa; i1.a_data = ad;
        i1.b_valid = bv; i1.b_addr = ba; i1.b_data = bd;
        i2.a_valid = av; i2.a_addr = aa; i2.a_data = ad;
        i2.b_valid = bv; i2.b_addr = ba; i2.b_data = bd;
    endtask

    // One clock cycle: apply inputs, compare every DUT with its schedule, then book any acceptance.
    task automatic step(input bit av, input logic [3:0] aa, input logic [7:0] ad,
                        input bit bv, input logic [3:0] ba, input logic [7:0] bd);
        logic [31:0] d, en, bz, ra, rb, er;
        logic [31:0] e_en;
        bit          idle, g;
        @(negedge clk);
        drive(av, aa, ad, bv, ba, bd);
        #1;
        for (int k = 0; k < 3; k++) begin
            idle = (cyc >= free_at[k]);
            if (av && !bv)      g = 1'b0;
            else if (bv && !av) g = 1'b1;
            else                g = m_ptr[k];
            e_en = 32'd0;
            if (cyc >= t_acc[k] + 1 + m_s[k] && cyc <= t_acc[k] + m_s[k] + m_p[k] &&
                cur_addr[k] < m_dp[k])
                e_en = 32'd1 << cur_addr[k];
            get_obs(k, d, en, bz, ra, rb, er);
            chk($sformatf("d%0d_lat_d c%0d", k, cyc), d, 32'(m_ld[k]));
            chk($sformatf("d%0d_lat_en c%0d", k, cyc), en, e_en);
            chk($sformatf("d%0d_busy c%0d", k, cyc), bz,
                32'(cyc > t_acc[k] && cyc < free_at[k]));
            chk($sformatf("d%0d_a_ready c%0d", k, cyc), ra, 32'(idle && av && !g));
            chk($sformatf("d%0d_b_ready c%0d", k, cyc), rb, 32'(idle && bv && g));
`ifdef LATCH_WR_SCHED_ERRCHK_EN
            chk($sformatf("d%0d_err c%0d", k, cyc), er, 32'(m_err[k]));
`endif
            if (idle && (av || bv)) begin
                t_acc[k]    = cyc;
                free_at[k]  = cyc + 1 + m_s[k] + m_p[k] + m_h[k];
                cur_addr[k] = g ? int'(ba) : int'(aa);
                m_ld[k]     = g ? bd : ad;
                if (cur_addr[k] >= m_dp[k]) m_err[k] = 1'b1;
                if (av && bv) m_ptr[k] = ~m_ptr[k];
            end
        end
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        int          pulse_cnt;
        logic [31:0] en_or;

        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
        model_reset();
        #12;
        chk("rst_lat_d0", 32'(ld0), 32'h0);
        chk("rst_lat_en0", 32'(en0), 32'h0);
        chk("rst_busy0", 32'(bz0), 32'h0);
        chk("rst_lat_en2", 32'(en2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, all *_CYC=1 on d0.
        step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00);
        chk("single_a_ready", 32'(i0.a_ready), 32'h1);
        idle_steps(1);
        chk("single_lat_d", 32'(ld0), 32'hA5);
        chk("single_busy1", 32'(bz0), 32'h1);
        idle_steps(1);
        chk("single_en_c2", 32'(en0), 32'h0008);
        idle_steps(1);
        chk("single_en_c3", 32'(en0), 32'h0000);
        chk("single_busy3", 32'(bz0), 32'h1);
        idle_steps(1);
        chk("single_idle_c4", 32'(bz0), 32'h0);
        idle_steps(6);

        // Contention: A->row1, B->row2, both always valid.
        for (int j = 0; j < 16; j++) begin
            step(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22);
            if (j % 4 == 2)
                chk($sformatf("fair_en j%0d", j), 32'(en0),
                    ((j / 4) % 2 == 0) ? 32'h0002 : 32'h0004);
        end
        idle_steps(8);

        // B arrives while A's sequence is in flight.
        step(1'b1, 4'd5, 8'h55, 1'b0, 4'd0, 8'h00);
        for (int j = 1; j <= 4; j++) begin
            step(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h66);
            chk($sformatf("wait_b_ready j%0d", j), 32'(i0.b_ready), (j == 4) ? 32'h1 : 32'h0);
        end
        idle_steps(10);

        // Stretched timing on d1: row 15, data 3C.
        step(1'b1, 4'd15, 8'h3C, 1'b0, 4'd0, 8'h00);
        pulse_cnt = 0;
        for (int j = 0; j < 10; j++) begin
            idle_steps(1);
            if (en1 == 16'h8000) begin
                pulse_cnt++;
                chk("timing_lat_d_in_pulse", 32'(ld1), 32'h3C);
            end
        end
        chk("timing_pulse_len", 32'(pulse_cnt), 32'd3);

        // Out-of-range row on d2 (DEPTH=12).
        step(1'b1, 4'd13, 8'h77, 1'b0, 4'd0, 8'h00);
        en_or = 32'h0;
        for (int j = 0; j < 6; j++) begin
            idle_steps(1);
            en_or = en_or | 32'(en2);
        end
        chk("oor_en_never", en_or, 32'h0);
`ifdef LATCH_WR_SCHED_ERRCHK_EN
        chk("oor_err_sticky", 32'(er2), 32'h1);
`endif
        idle_steps(4);

        // Randomized traffic.
        for (int j = 0; j < 400; j++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        end
        idle_steps(10);

        // Reset while row 4 is pulsing.
        step(1'b1, 4'd4, 8'h99, 1'b0, 4'd0, 8'h00);
        idle_steps(2);
        chk("mid_en_before", 32'(en0), 32'h0010);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(en0), 32'h0);
        chk("mid_rst_busy", 32'(bz0), 32'h0);
        chk("mid_rst_lat_d", 32'(ld0), 32'h0);
        chk("mid_rst_en1", 32'(en1), 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'h5A);
        chk("post_rst_b_ready", 32'(i0.b_ready), 32'h1);
        idle_steps(2);
        chk("post_rst_en", 32'(en0), 32'h0001);
        idle_steps(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/latch_wr_sched.md
Name: latch_wr_sched

Overview:
- Write scheduler for a latch-based storage array built from transparent-high LATCH cells: DEPTH rows × WIDTH bits.
- Arbitrates between two write requesters (A, B) with round-robin priority.
- Sequences each write as data setup, then a single-row enable pulse, then data hold, so the latch D/CLK setup and hold windows are met by construction.
- Sits between CPU-side write sources and the latch array macro.

Parameters:
- WIDTH, 8, data bits per row.
- DEPTH, 16, number of latch rows; one enable per row.
- AW, 4, address width; must satisfy 2**AW >= DEPTH.
- SETUP_CYC, 1, cycles LAT_D is stable before the enable pulse (>=1).
- PULSE_CYC, 1, cycles the row enable is high (>=1).
- HOLD_CYC, 1, cycles LAT_D is held after the enable falls (>=1).

Ports:
- CLK, in, 1, rising-edge clock.
- RST_N, in, 1, asynchronous active-low reset.
- A_VALID, in, 1, requester A write request.
- A_ADDR, in, AW, requester A row address.
- A_DATA, in, WIDTH, requester A write data.
- A_READY, out, 1, requester A accepted this cycle.
- B_VALID, in, 1, requester B write request.
- B_ADDR, in, AW, requester B row address.
- B_DATA, in, WIDTH, requester B write data.
- B_READY, out, 1, requester B accepted this cycle.
- LAT_D, out, WIDTH, shared data bus driving the D pins of all rows.
- LAT_EN, out, DEPTH, one-hot row enables driving the latch CLK pins.
- BUSY, out, 1, write sequence in progress.

Behaviour:
- Reset (async assert, sync release): state=IDLE, LAT_EN=0, LAT_D=0, BUSY=0, A_READY=B_READY=0, priority pointer=A.
- FSM states: IDLE, SETUP, PULSE, HOLD. A single down-counter cnt loads on each state entry.
- IDLE:
  - READY is combinational: X_READY = (state==IDLE) & X_VALID & grant==X.
  - Grant: if only one requester is valid, that one wins. If both are valid, the pointer owner wins, and the pointer then flips to the other requester.
  - On acceptance: register address and data, drive LAT_D with the data on the next edge, go to SETUP, cnt=SETUP_CYC-1.
- SETUP: LAT_EN=0, LAT_D stable. When cnt==0, go to PULSE with cnt=PULSE_CYC-1.
- PULSE: LAT_EN = one-hot(addr). Must be driven directly from a flop, with no combinational decode glitch on any row. When cnt==0, go to HOLD with cnt=HOLD_CYC-1.
- HOLD: LAT_EN=0, LAT_D unchanged. When cnt==0, go to IDLE.
- BUSY=1 in SETUP, PULSE and HOLD.
- Latency: with all *_CYC=1, acceptance at edge 0, LAT_EN rises at edge 2 and falls at edge 3, IDLE is re-entered at edge 4. Throughput is one write per (1+SETUP_CYC+PULSE_CYC+HOLD_CYC) cycles.
- LAT_D changes only on the IDLE→SETUP edge. It holds its last value while idle.
- At most one LAT_EN bit is high at any time. LAT_EN is never high outside PULSE.
- Address >= DEPTH: sequence runs normally but LAT_EN stays 0 (write dropped).
- A requester dropping VALID before READY is legal: no acceptance occurs and the pointer is unchanged.
- VALID asserted during BUSY waits, with no READY; arbitration happens at the next IDLE.
- RST_N asserted mid-sequence: LAT_EN drops to 0 immediately (asynchronously) and the in-flight write is abandoned.

Optional Feature:
- Macro: LATCH_WR_SCHED_ERRCHK_EN.
- Defined: adds output port ERR (1 bit, reset 0). ERR is a sticky flag set on acceptance of an address >= DEPTH, and also set if any LAT_EN bit is high outside PULSE (internal assertion check). It clears only on reset.
- Undefined: no ERR port and no check logic. Out-of-range writes are silently dropped.

Decomposition:
- Package latch_sched_pkg:
  - FSM state enum (IDLE, SETUP, PULSE, HOLD), 2-bit encoding.
  - Requester-ID constants REQ_A=0, REQ_B=1.
  - Function for one-hot decode with range check.
- One natural sub-module: latch_rr_arb2, the 2-input round-robin arbiter (valid in, grant out, pointer update on accept).

Test Plan:
- Single write: A_VALID=1, A_ADDR=3, A_DATA=8'hA5, all *_CYC=1 → A_READY=1 at cycle 0; LAT_D=8'hA5 from cycle 1; LAT_EN=16'h0008 only in cycle 2; BUSY high for cycles 1–3; idle again at cycle 4.
- Contention fairness: A and B both valid continuously (A→addr 1, B→addr 2) → grants alternate A,B,A,B, one every 4 cycles; LAT_EN pulses 0x0002, 0x0004, 0x0002, …
- Timing params: SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, write addr 15 data 8'h3C → LAT_D stable 2 cycles before LAT_EN[15]; LAT_EN[15] high exactly 3 cycles; LAT_D unchanged for 2 cycles after.
- Out-of-range: DEPTH=12, write addr 13 → LAT_EN=0 throughout a full 4-cycle sequence; with LATCH_WR_SCHED_ERRCHK_EN defined, ERR=1 from cycle 1 and stays set.
- Reset mid-pulse: drop RST_N while LAT_EN=0x0010 → LAT_EN=0, BUSY=0, LAT_D=0 immediately; after release, a B write to addr 0 completes normally.
- Wait during busy: B_VALID rises in cycle 1 of an A sequence → B_READY stays 0 until IDLE at cycle 4, then B_READY=1.
